multi_edge_detector: RTL
========================

# multi_edge_detector

Parametrised, multi-channel successor to the single-bit rising-edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable number of cycles, and detects rising, falling or both edges, with the edge type selected per channel at run time. Each channel drives a one-cycle pulse and a sticky, write-one-to-clear pending flag; the pending flags are ORed into one interrupt for the control/status block.

## Interface
- WIDTH, 8: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- FILTER_LEN, 4: consecutive cycles a new synchronised value must hold before it is accepted (≥1).
- INIT_LEVEL, 0: reset value of every synchroniser flop and of each filtered level (0 or 1, all channels).

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  raw asynchronous channel inputs.
- rise_en  input  WIDTH  per-channel rising-edge enable.
- fall_en  input  WIDTH  per-channel falling-edge enable.
- clr  input  WIDTH  write-one-to-clear for pending, sampled every cycle.
- level  output  WIDTH  filtered, synchronised channel level.
- pulse  output  WIDTH  one-cycle strobe per enabled, accepted edge.
- pending  output  WIDTH  sticky event flags.
- irq  output  1  OR of pending.

## Operation
- Reset (rst high, asynchronous): synchroniser flops = INIT_LEVEL; level = INIT_LEVEL; filter counters = 0; pulse = 0; pending = 0; irq = 0. All outputs are registered except irq (combinational OR of the pending registers).
- Per channel, fully independent:
  - Synchroniser: SYNC_STAGES-flop shift chain; last stage is s.
  - Filter: counter of width max(1, clog2(FILTER_LEN)). If s == level, counter <= 0. If s != level and counter == FILTER_LEN-1: level <= s, counter <= 0. Otherwise counter increments. A disagreement that lasts fewer than FILTER_LEN cycles never changes level; an agreeing cycle restarts the count. With FILTER_LEN = 1, level follows s with one cycle of delay.
  - Edge: on the edge where level flips 0->1, pulse <= rise_en; where it flips 1->0, pulse <= fall_en; on every other edge, pulse <= 0. rise_en/fall_en are sampled on the flip edge only.
  - Pending: on the edge where pulse is set, pending <= 1. Otherwise, if clr = 1, pending <= 0. When set and clear hit the same edge, set wins and the event is never lost.
- Disabling an edge type does not affect level or the filter. It only suppresses pulse and pending for that type.
- Enable changes take effect on the next flip. Already-pending flags stay until cleared.

## Timing
- Latency: when din changes and is stable before edge k, level and pulse update on edge k + SYNC_STAGES + FILTER_LEN − 1. With defaults this is edge k+5, so pulse is high for the cycle after edge k+5.
- pulse width is exactly 1 cycle. Minimum spacing between pulses on one channel is FILTER_LEN cycles.
- pending rises together with pulse, and irq rises in the same cycle. clr asserted before edge j clears pending at edge j.
- Reset asserted mid-filter or mid-pulse: all state goes to reset values immediately. After release, a din that differs from INIT_LEVEL produces a normal filtered edge (a real edge after the full latency).
- Meeting setup/hold on din is not required. The synchroniser absorbs metastability, and only s feeds the logic.

## Test plan
- Defaults, ch0 rise_en=1: din[0] 0->1 stable before edge 10 -> level[0] = 1 and pulse[0] = 1 for exactly the cycle after edge 15, pending[0] = 1 and irq = 1 from edge 15. No activity on other channels.
- Glitch reject: din[3] high for 3 cycles, then low -> level, pulse and pending stay 0. A 4-cycle high is accepted, giving a rising pulse then, with fall_en=1, a falling pulse.
- Mode mix: ch1 rise only, ch2 fall only, ch4 both, all driven with the same 0->1->0 square wave (20-cycle phases) -> pulses ch1:1, ch2:1, ch4:2. level toggles on all three.
- Clear collision: pending[5] = 1 and clr[5] asserted on the same edge that a new ch5 pulse sets it -> pending[5] stays 1. clr[5] on the next edge -> 0, and irq drops if no other pending flag is set.
- Reset mid-operation: assert rst while ch6's counter = 2 and pulse[7] = 1 -> all outputs 0 immediately. Release with din[6] = 1 -> rising pulse at full latency after release.
- Parameter sweep WIDTH=1/FILTER_LEN=1/SYNC_STAGES=3 and INIT_LEVEL=1 -> latency = SYNC_STAGES + FILTER_LEN − 1 edges. With INIT_LEVEL=1, din held high through reset produces no pulse.

Source files
------------

// File: rtl/multi_edge_detector.sv
// ============================================================================
// multi_edge_detector: per-channel synchroniser, glitch filter and edge
// detector with sticky write-one-to-clear pending flags and an ORed interrupt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_edge_detector #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter bit INIT_LEVEL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] pending,
   output logic             irq
);

   localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   pulse_q, pulse_d;
      logic                   pending_q, pending_d;
      logic                   sync_s;

      assign sync_s = sync_q[SYNC_STAGES-1];

      always_comb begin
         sync_d  = {sync_q[SYNC_STAGES-2:0], din[i]};
         level_d = level_q;
         cnt_d   = cnt_q;

         // Any agreeing cycle restarts the qualification count.
         if (sync_s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            level_d = sync_s;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end

         pulse_d = 1'b0;
         if (level_d && !level_q) begin
            pulse_d = rise_en[i];
         end else if (!level_d && level_q) begin
            pulse_d = fall_en[i];
         end

         // A new event outranks a simultaneous clear so it is never lost.
         pending_d = pulse_d | (pending_q & ~clr[i]);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q    <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q     <= '0;
            level_q   <= INIT_LEVEL;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
         end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
         end
      end

      assign level[i]   = level_q;
      assign pulse[i]   = pulse_q;
      assign pending[i] = pending_q;
   end

   assign irq = |pending;

endmodule

`default_nettype wire
